// File: rtl/img_sram_streamer.sv
// Row-major image SRAM reader producing an 8-bit valid/ready byte stream.
// Optional end-of-line / end-of-frame sideband under IMG_STREAM_TLAST_EN.
package img_sram_pkg;
    localparam int ROW_W  = 8;
    localparam int COL_W  = 8;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              write_en;
        logic              sense_en;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] din;
    } img_sram_ctrl_t;
endpackage

module img_sram_streamer
    import img_sram_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [7:0]     nrows,
    input  logic [7:0]     ncols,
    output logic           busy,
    output logic           done,
    input  logic [7:0]     sram_dout_in,
    output img_sram_ctrl_t sram_ctrl,
    output logic [7:0]     m_data,
    output logic           m_valid,
    input  logic           m_ready
`ifdef IMG_STREAM_TLAST_EN
    ,
    output logic           m_eol,
    output logic           m_eof
`endif
);

`ifdef IMG_STREAM_TLAST_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_ST} state_t;
    state_t state;

    logic [7:0]    nrows_l, ncols_l, row_idx, col_idx;
    logic [EW-1:0] fifo [2];
    logic          rd_ptr, wr_ptr, pend;
    logic [1:0]    occ, occ_nxt;
    logic [2:0]    occ_pend;
    logic          pop, push, issue, last_col, last_row;
    logic [EW-1:0] push_data, head;

`ifdef IMG_STREAM_TLAST_EN
    logic pend_eol, pend_eof;
    assign push_data = {pend_eof, pend_eol, sram_dout_in};
    assign m_eol     = m_valid & head[8];
    assign m_eof     = m_valid & head[9];
`else
    assign push_data = sram_dout_in;
`endif

    assign head     = fifo[rd_ptr];
    assign m_data   = head[7:0];
    assign m_valid  = (occ != 2'd0);
    assign pop      = m_valid && m_ready;
    assign push     = pend;
    assign occ_nxt  = occ + {1'b0, push} - {1'b0, pop};
    // Slots already claimed by buffered or in-flight data, net of this cycle's pop.
    assign occ_pend = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
    assign issue    = (state == RUN) && (occ_pend < 3'd2);
    assign last_col = (col_idx == ncols_l - 8'd1);
    assign last_row = (row_idx == nrows_l - 8'd1);

    always_comb begin
        sram_ctrl     = '0;
        sram_ctrl.row = row_idx;
        sram_ctrl.col = col_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            nrows_l <= '0;
            ncols_l <= '0;
            row_idx <= '0;
            col_idx <= '0;
            pend    <= 1'b0;
            occ     <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            fifo[0] <= '0;
            fifo[1] <= '0;
`ifdef IMG_STREAM_TLAST_EN
            pend_eol <= 1'b0;
            pend_eof <= 1'b0;
`endif
        end else begin
            pend <= issue;
            occ  <= occ_nxt;
            if (push) begin
                fifo[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (issue) begin
`ifdef IMG_STREAM_TLAST_EN
                pend_eol <= last_col;
                pend_eof <= last_col && last_row;
`endif
                if (last_col) begin
                    col_idx <= '0;
                    row_idx <= row_idx + 8'd1;
                end else begin
                    col_idx <= col_idx + 8'd1;
                end
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        nrows_l <= nrows;
                        ncols_l <= ncols;
                        row_idx <= '0;
                        col_idx <= '0;
                        busy    <= 1'b1;
                        if (nrows == 8'd0 || ncols == 8'd0) begin
                            state <= DONE_ST;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: if (issue && last_row && last_col) state <= DRAIN;
                // Leave on the edge of the final pop so done follows it by one cycle.
                DRAIN: if (occ_nxt == 2'd0 && !pend) begin
                    state <= DONE_ST;
                    done  <= 1'b1;
                end
                DONE_ST: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_sram_streamer.sv
// Directed bench for img_sram_streamer; SRAM model returns 16*row+col one cycle late.
// Define IMG_STREAM_TLAST_EN to also exercise the eol/eof sideband.
module tb_img_sram_streamer;
    import img_sram_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [7:0]     nrows = '0, ncols = '0;
    logic           busy, done;
    logic [7:0]     sram_dout_in = '0;
    img_sram_ctrl_t sram_ctrl;
    logic [7:0]     m_data;
    logic           m_valid;
    logic           m_ready = 1'b0;
`ifdef IMG_STREAM_TLAST_EN
    logic           m_eol, m_eof;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_data [$];
    logic       got_eol  [$];
    logic       got_eof  [$];

    img_sram_streamer dut (
        .clk(clk), .rst(rst), .start(start), .nrows(nrows), .ncols(ncols),
        .busy(busy), .done(done), .sram_dout_in(sram_dout_in), .sram_ctrl(sram_ctrl),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef IMG_STREAM_TLAST_EN
        , .m_eol(m_eol), .m_eof(m_eof)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        sram_dout_in <= {sram_ctrl.row[3:0], sram_ctrl.col[3:0]};

    // Pulse start; returns at the negedge right after the sampling edge (cycle 0).
    task automatic kick(input logic [7:0] nr, input logic [7:0] nc);
        @(negedge clk);
        nrows = nr; ncols = nc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives m_ready from a 4-cycle pattern and records beats; stops on done or nstop beats.
    task automatic run_stream(input int nstop, input logic [3:0] pat, input bit disturb,
                              output int first_vld, output int last_beat, output int done_at,
                              output int unstable, output int max_op);
        bit         prev_hold = 1'b0;
        logic [7:0] prev_data = '0;
        got_data.delete(); got_eol.delete(); got_eof.delete();
        first_vld = -1; last_beat = -1; done_at = -1; unstable = 0; max_op = 0;
        for (int c = 0; c < 200; c++) begin
            m_ready = pat[c % 4];
            start = 1'b0;
            if (disturb && c == 4) begin
                start = 1'b1;
                ncols = 8'd7;
            end
            if (prev_hold && (!m_valid || m_data !== prev_data)) unstable++;
            if (int'(dut.occ) + int'(dut.pend) > max_op) max_op = int'(dut.occ) + int'(dut.pend);
            if (m_valid && first_vld < 0) first_vld = c;
            if (done) begin
                done_at = c;
                break;
            end
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
`ifdef IMG_STREAM_TLAST_EN
                got_eol.push_back(m_eol);
                got_eof.push_back(m_eof);
`endif
                last_beat = c;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            if (nstop > 0 && got_data.size() == nstop) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", m_data); end
        if (sram_ctrl.row !== 8'd0) begin n_fail++; $display("FAIL reset_row: got %0d want 0", sram_ctrl.row); end
        if (sram_ctrl.col !== 8'd0) begin n_fail++; $display("FAIL reset_col: got %0d want 0", sram_ctrl.col); end
        rst = 1'b0;
    endtask

    task automatic test_stream_full;
        int fv, lb, da, us, mo;
        kick(8'd3, 8'd4);
        run_stream(0, 4'b1111, 1'b0, fv, lb, da, us, mo);
        n_checks += 4;
        if (got_data.size() != 12) begin n_fail++; $display("FAIL full_count: got %0d want 12", got_data.size()); end
        if (fv != 2) begin n_fail++; $display("FAIL full_first_valid: got cycle %0d want 2", fv); end
        if (lb != 13) begin n_fail++; $display("FAIL full_last_beat: got cycle %0d want 13", lb); end
        if (da != 14) begin n_fail++; $display("FAIL full_done: got cycle %0d want 14", da); end
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            logic [7:0] e = 8'((i / 4) * 16 + (i % 4));
            n_checks++;
            if (got_data[i] !== e) begin n_fail++; $display("FAIL full_byte%0d: got %h want %h", i, got_data[i], e); end
        end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_in_done: got %b want 1", busy); end
        @(negedge clk);
        n_checks += 2;
        if (done !== 1'b0) begin n_fail++; $display("FAIL full_done_pulse: got %b want 0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_backpressure;
        int fv, lb, da, us, mo;
        kick(8'd3, 8'd4);
        run_stream(0, 4'b1001, 1'b0, fv, lb, da, us, mo);
        n_checks += 4;
        if (got_data.size() != 12) begin n_fail++; $display("FAIL bp_count: got %0d want 12", got_data.size()); end
        if (us != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", us); end
        if (mo > 2) begin n_fail++; $display("FAIL bp_occ_pend: got %0d want <=2", mo); end
        if (da < 0 || da != lb + 1) begin n_fail++; $display("FAIL bp_done: got cycle %0d want %0d", da, lb + 1); end
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            logic [7:0] e = 8'((i / 4) * 16 + (i % 4));
            n_checks++;
            if (got_data[i] !== e) begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, got_data[i], e); end
        end
        @(negedge clk);
    endtask

    task automatic test_zero_dim;
        int vld_seen = 0;
        m_ready = 1'b1;
        kick(8'd0, 8'd5);
        n_checks += 2;
        if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_hi: got %b want 1", busy); end
        if (m_valid) vld_seen++;
        @(negedge clk);
        n_checks += 2;
        if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_end: got %b want 0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_lo: got %b want 0", busy); end
        repeat (4) begin
            if (m_valid) vld_seen++;
            @(negedge clk);
        end
        n_checks++;
        if (vld_seen != 0) begin n_fail++; $display("FAIL zero_no_valid: got %0d valid cycles want 0", vld_seen); end
    endtask

    task automatic test_reset_mid;
        int fv, lb, da, us, mo;
        kick(8'd3, 8'd4);
        run_stream(5, 4'b1111, 1'b0, fv, lb, da, us, mo);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks += 4;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", m_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (sram_ctrl.row !== 8'd0) begin n_fail++; $display("FAIL rstmid_row: got %0d want 0", sram_ctrl.row); end
        if (sram_ctrl.col !== 8'd0) begin n_fail++; $display("FAIL rstmid_col: got %0d want 0", sram_ctrl.col); end
        kick(8'd3, 8'd4);
        run_stream(0, 4'b1111, 1'b0, fv, lb, da, us, mo);
        n_checks += 2;
        if (got_data.size() != 12) begin n_fail++; $display("FAIL rstmid_count: got %0d want 12", got_data.size()); end
        if (got_data.size() > 0 && got_data[0] !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_first: got %h want 00", got_data[0]);
        end
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            logic [7:0] e = 8'((i / 4) * 16 + (i % 4));
            n_checks++;
            if (got_data[i] !== e) begin n_fail++; $display("FAIL rstmid_byte%0d: got %h want %h", i, got_data[i], e); end
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int fv, lb, da, us, mo;
        kick(8'd3, 8'd4);
        run_stream(0, 4'b1111, 1'b1, fv, lb, da, us, mo);
        ncols = 8'd4;
        n_checks += 2;
        if (got_data.size() != 12) begin n_fail++; $display("FAIL ign_count: got %0d want 12", got_data.size()); end
        if (da != 14) begin n_fail++; $display("FAIL ign_done: got cycle %0d want 14", da); end
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            logic [7:0] e = 8'((i / 4) * 16 + (i % 4));
            n_checks++;
            if (got_data[i] !== e) begin n_fail++; $display("FAIL ign_byte%0d: got %h want %h", i, got_data[i], e); end
        end
        @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_restart: got busy %b want 0", busy); end
    endtask

`ifdef IMG_STREAM_TLAST_EN
    task automatic test_tlast;
        int fv, lb, da, us, mo;
        kick(8'd2, 8'd3);
        run_stream(0, 4'b1111, 1'b0, fv, lb, da, us, mo);
        n_checks++;
        if (got_data.size() != 6) begin n_fail++; $display("FAIL tlast_count: got %0d want 6", got_data.size()); end
        for (int i = 0; i < 6 && i < got_eol.size(); i++) begin
            logic ee = (i == 2 || i == 5);
            logic ef = (i == 5);
            n_checks += 2;
            if (got_eol[i] !== ee) begin n_fail++; $display("FAIL tlast_eol%0d: got %b want %b", i, got_eol[i], ee); end
            if (got_eof[i] !== ef) begin n_fail++; $display("FAIL tlast_eof%0d: got %b want %b", i, got_eof[i], ef); end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
        test_stream_full;
        test_backpressure;
        test_zero_dim;
        test_reset_mid;
        test_ignore_start;
`ifdef IMG_STREAM_TLAST_EN
        test_tlast;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
